// File: rtl/nota_pkg.sv
// Shared constants for the note detector.
// Holds the note codes, the inclusive period bounds (in 250 kHz ticks) for each of
// the 12 chromatic notes Do..Si, the nominal prescaler divide ratio and the FSM
// state type.
package nota_pkg;

   // Note codes reported on nota.
   localparam logic [3:0] DO        = 4'd0;
   localparam logic [3:0] DOS       = 4'd1;
   localparam logic [3:0] RE        = 4'd2;
   localparam logic [3:0] RES       = 4'd3;
   localparam logic [3:0] MI        = 4'd4;
   localparam logic [3:0] FA        = 4'd5;
   localparam logic [3:0] FAS       = 4'd6;
   localparam logic [3:0] SOL       = 4'd7;
   localparam logic [3:0] SOLS      = 4'd8;
   localparam logic [3:0] LA        = 4'd9;
   localparam logic [3:0] LAS       = 4'd10;
   localparam logic [3:0] SI        = 4'd11;
   localparam logic [3:0] NOTA_NONE = 4'hF;

   // Inclusive period bounds in ticks, valid for a 250 kHz tick only.
   localparam logic [9:0] DO_LO   = 10'd928;
   localparam logic [9:0] DO_HI   = 10'd1000;
   localparam logic [9:0] DOS_LO  = 10'd876;
   localparam logic [9:0] DOS_HI  = 10'd927;
   localparam logic [9:0] RE_LO   = 10'd827;
   localparam logic [9:0] RE_HI   = 10'd875;
   localparam logic [9:0] RES_LO  = 10'd781;
   localparam logic [9:0] RES_HI  = 10'd826;
   localparam logic [9:0] MI_LO   = 10'd737;
   localparam logic [9:0] MI_HI   = 10'd780;
   localparam logic [9:0] FA_LO   = 10'd696;
   localparam logic [9:0] FA_HI   = 10'd736;
   localparam logic [9:0] FAS_LO  = 10'd657;
   localparam logic [9:0] FAS_HI  = 10'd695;
   localparam logic [9:0] SOL_LO  = 10'd620;
   localparam logic [9:0] SOL_HI  = 10'd656;
   localparam logic [9:0] SOLS_LO = 10'd585;
   localparam logic [9:0] SOLS_HI = 10'd619;
   localparam logic [9:0] LA_LO   = 10'd552;
   localparam logic [9:0] LA_HI   = 10'd584;
   localparam logic [9:0] LAS_LO  = 10'd521;
   localparam logic [9:0] LAS_HI  = 10'd551;
   localparam logic [9:0] SI_LO   = 10'd480;
   localparam logic [9:0] SI_HI   = 10'd520;

   function automatic int unsigned tick_div(input int unsigned frec_in,
                                            input int unsigned frec_tick);
      return frec_in / frec_tick;
   endfunction

   // Nominal divide ratio: 25 MHz system clock down to the 250 kHz tick.
   localparam int unsigned TICK_DIV = tick_div(25000000, 250000);

   typedef enum logic {StIdle, StMeasure} state_t;

endpackage

// File: rtl/period_classifier.sv
// Combinational lookup from a measured period (ticks) to a chromatic note code.
// Ports:
//   period     in   10  measured period in ticks
//   note_class out   4  note code 0..11, or NOTA_NONE when outside every band
module period_classifier
   import nota_pkg::*;
(
   input  logic [9:0] period,
   output logic [3:0] note_class
);

   always_comb begin
      note_class = NOTA_NONE;
      if      (period >= DO_LO   && period <= DO_HI)   note_class = DO;
      else if (period >= DOS_LO  && period <= DOS_HI)  note_class = DOS;
      else if (period >= RE_LO   && period <= RE_HI)   note_class = RE;
      else if (period >= RES_LO  && period <= RES_HI)  note_class = RES;
      else if (period >= MI_LO   && period <= MI_HI)   note_class = MI;
      else if (period >= FA_LO   && period <= FA_HI)   note_class = FA;
      else if (period >= FAS_LO  && period <= FAS_HI)  note_class = FAS;
      else if (period >= SOL_LO  && period <= SOL_HI)  note_class = SOL;
      else if (period >= SOLS_LO && period <= SOLS_HI) note_class = SOLS;
      else if (period >= LA_LO   && period <= LA_HI)   note_class = LA;
      else if (period >= LAS_LO  && period <= LAS_HI)  note_class = LAS;
      else if (period >= SI_LO   && period <= SI_HI)   note_class = SI;
   end

endmodule

// File: rtl/note_detector.sv
// Measures the period of an incoming square wave and reports which chromatic note
// (Do..Si) it is, once Stable consecutive periods agree.
// Ports:
//   clockIn    in   1  system clock
//   reset      in   1  synchronous active-high reset
//   ondaIn     in   1  asynchronous square-wave input
//   nota       out  4  locked note code 0..11, 15 = none
//   notaValida out  1  high while nota holds a note 0..11
//   nuevaNota  out  1  one-cycle pulse when nota/notaValida change
//   periodo    out 10  last measured period in ticks
module note_detector
   import nota_pkg::*;
#(
   parameter int unsigned FrecIn   = 25000000,
   parameter int unsigned FrecTick = 250000,
   parameter int unsigned Stable   = 3,     // 1..7
   parameter int unsigned Timeout  = 1023
) (
   input  logic       clockIn,
   input  logic       reset,
   input  logic       ondaIn,
   output logic [3:0] nota,
   output logic       notaValida,
   output logic       nuevaNota,
   output logic [9:0] periodo
);

   localparam int unsigned TickDiv = tick_div(FrecIn, FrecTick);
   // Prescaler sized for at least the nominal divider.
   localparam int unsigned PrescW  = $clog2((TickDiv > TICK_DIV) ? TickDiv : TICK_DIV);
   localparam logic [2:0]  StableC  = 3'(Stable);
   localparam logic [9:0]  TimeoutC = 10'(Timeout);

   logic              sync1_q, sync2_q, prev_q;
   logic [PrescW-1:0] presc_q;
   state_t            state_q, state_d;
   logic [9:0]        tick_count_q, tick_count_d;
   logic [9:0]        periodo_q, periodo_d;
   logic [3:0]        cand_q, cand_d;
   logic [2:0]        match_cnt_q, match_cnt_d;
   logic [3:0]        nota_q, nota_d;
   logic              valida_q, valida_d;
   logic              nueva_q, nueva_d;
   logic              rise, tick, timeout;
   logic [3:0]        clase;

   assign rise    = sync2_q & ~prev_q;
   assign tick    = (presc_q == PrescW'(TickDiv - 1));
   // An edge always wins over an expiring count.
   assign timeout = (state_q == StMeasure) && !rise && (tick_count_q == TimeoutC);

   period_classifier u_classifier (
      .period     (tick_count_q),
      .note_class (clase)
   );

   // Synchronizer, edge history and prescaler.
   always_ff @(posedge clockIn) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         presc_q <= '0;
      end else begin
         sync1_q <= ondaIn;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         presc_q <= tick ? '0 : presc_q + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clockIn) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (rise)    state_d = StMeasure;
         StMeasure: if (timeout) state_d = StIdle;
      endcase
   end

   // Measurement, stability and output next values.
   always_comb begin
      tick_count_d = tick_count_q;
      periodo_d    = periodo_q;
      cand_d       = cand_q;
      match_cnt_d  = match_cnt_q;
      nota_d       = nota_q;
      valida_d     = valida_q;
      nueva_d      = 1'b0;

      // Publish the candidate the cycle after its run reaches Stable.
      if (match_cnt_q == StableC && cand_q != nota_q) begin
         nota_d   = cand_q;
         valida_d = (cand_q != NOTA_NONE);
         nueva_d  = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            // Arming edge: start counting, no measurement yet.
            if (rise) tick_count_d = '0;
         end
         StMeasure: begin
            if (rise) begin
               periodo_d    = tick_count_q;
               tick_count_d = '0;
               if (clase == cand_q) begin
                  if (match_cnt_q < StableC) match_cnt_d = match_cnt_q + 3'd1;
               end else begin
                  cand_d      = clase;
                  match_cnt_d = 3'd1;
               end
            end else if (timeout) begin
               nota_d      = NOTA_NONE;
               valida_d    = 1'b0;
               cand_d      = NOTA_NONE;
               match_cnt_d = '0;
               nueva_d     = valida_q;
            end else if (tick) begin
               tick_count_d = tick_count_q + 10'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clockIn) begin
      if (reset) begin
         tick_count_q <= '0;
         periodo_q    <= '0;
         cand_q       <= NOTA_NONE;
         match_cnt_q  <= '0;
         nota_q       <= NOTA_NONE;
         valida_q     <= 1'b0;
         nueva_q      <= 1'b0;
      end else begin
         tick_count_q <= tick_count_d;
         periodo_q    <= periodo_d;
         cand_q       <= cand_d;
         match_cnt_q  <= match_cnt_d;
         nota_q       <= nota_d;
         valida_q     <= valida_d;
         nueva_q      <= nueva_d;
      end
   end

   assign nota       = nota_q;
   assign notaValida = valida_q;
   assign nuevaNota  = nueva_q;
   assign periodo    = periodo_q;

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector: two instances (Stable=3 and Stable=1) share one input.
// A fast clock ratio (2 clocks per tick) keeps real note periods short.
module tb_note_detector;

   localparam int FREC_IN   = 500000;
   localparam int FREC_TICK = 250000;
   localparam int DIV       = FREC_IN / FREC_TICK;
   localparam int TOUT      = 1023;
   localparam int NONE      = 15;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic onda = 1'b0;
   logic [3:0] nota_a, nota_b;
   logic       val_a, val_b, nue_a, nue_b;
   logic [9:0] per_a, per_b;

   always #5 clk = ~clk;

   note_detector #(.FrecIn(FREC_IN), .FrecTick(FREC_TICK), .Stable(3), .Timeout(TOUT)) dut_a (
      .clockIn(clk), .reset(rst), .ondaIn(onda),
      .nota(nota_a), .notaValida(val_a), .nuevaNota(nue_a), .periodo(per_a)
   );

   note_detector #(.FrecIn(FREC_IN), .FrecTick(FREC_TICK), .Stable(1), .Timeout(TOUT)) dut_b (
      .clockIn(clk), .reset(rst), .ondaIn(onda),
      .nota(nota_b), .notaValida(val_b), .nuevaNota(nue_b), .periodo(per_b)
   );

   int total = 0;
   int bad = 0;
   int pulses_a = 0;
   int pulses_b = 0;

   int lo_b[12] = '{928, 876, 827, 781, 737, 696, 657, 620, 585, 552, 521, 480};
   int hi_b[12] = '{1000, 927, 875, 826, 780, 736, 695, 656, 619, 584, 551, 520};

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int classify(input int p);
      for (int n = 0; n < 12; n++) if (p >= lo_b[n] && p <= hi_b[n]) return n;
      return NONE;
   endfunction

   // Ticks land on posedges t > r with (t - r) a multiple of DIV; count those
   // strictly between the previous edge a and the current posedge b.
   function automatic int ticks_in(input int a, input int b, input int r);
      return ((b - 1 - r) / DIV) - ((a - r) / DIV);
   endfunction

   // Reference model, one step per posedge.
   int  cyc = 0, r_cyc = 0, t_prev = 0, m_per = 0, tc = 0, c = 0;
   bit  mdl_on = 1'b0, meas = 1'b0, h1 = 1'b0, h2 = 1'b0, h3 = 1'b0, edge_now = 1'b0;
   int  stab[2] = '{3, 1};
   int  m_nota[2], m_val[2], m_nue[2], cand[2], cnt[2];
   bit  upd[2];

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         r_cyc = cyc; h1 = 0; h2 = 0; h3 = 0; meas = 0; t_prev = cyc; m_per = 0;
         for (int i = 0; i < 2; i++) begin
            m_nota[i] = NONE; m_val[i] = 0; m_nue[i] = 0; cand[i] = NONE; cnt[i] = 0;
            upd[i] = 0;
         end
         mdl_on = 1'b1;
      end else if (mdl_on) begin
         // Pin edge seen two samples ago acts now.
         edge_now = h2 && !h3;
         tc = ticks_in(t_prev, cyc, r_cyc);
         for (int i = 0; i < 2; i++) begin
            m_nue[i] = 0;
            if (upd[i]) begin
               upd[i] = 0;
               m_nota[i] = cand[i];
               m_val[i] = (cand[i] != NONE);
               m_nue[i] = 1;
            end
         end
         if (edge_now) begin
            if (meas) begin
               m_per = tc;
               c = classify(tc);
               for (int i = 0; i < 2; i++) begin
                  if (c == cand[i]) cnt[i] = (cnt[i] + 1 > stab[i]) ? stab[i] : cnt[i] + 1;
                  else begin cand[i] = c; cnt[i] = 1; end
                  upd[i] = (cnt[i] == stab[i]) && (cand[i] != m_nota[i]);
               end
            end
            meas = 1'b1;
            t_prev = cyc;
         end else if (meas && tc == TOUT) begin
            meas = 1'b0;
            for (int i = 0; i < 2; i++) begin
               m_nue[i] = m_val[i]; m_nota[i] = NONE; m_val[i] = 0;
               cand[i] = NONE; cnt[i] = 0; upd[i] = 0;
            end
         end
         h3 = h2; h2 = h1; h1 = onda;
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (mdl_on) begin
         chk("nota_a", nota_a, m_nota[0]);
         chk("valida_a", val_a, m_val[0]);
         chk("nueva_a", nue_a, m_nue[0]);
         chk("periodo_a", per_a, m_per);
         chk("nota_b", nota_b, m_nota[1]);
         chk("valida_b", val_b, m_val[1]);
         chk("nueva_b", nue_b, m_nue[1]);
         chk("periodo_b", per_b, m_per);
         if (nue_a) pulses_a++;
         if (nue_b) pulses_b++;
      end
   end

   // Drive n periods of 'ticks' ticks each, 50% duty, optional +/-1 clock jitter.
   task automatic wave(input int ticks, input int n, input bit jit);
      int len;
      for (int k = 0; k < n; k++) begin
         len = ticks * DIV;
         if (jit) len = len + int'($urandom_range(2)) - 1;
         onda = 1'b1;
         repeat (len / 2) @(negedge clk);
         onda = 1'b0;
         repeat (len - len / 2) @(negedge clk);
      end
   endtask

   initial begin
      int p0, q0, n, sel, tks, runs;

      // Pin the model's note table.
      chk("cls_568", classify(568), 9);
      chk("cls_1000", classify(1000), 0);
      chk("cls_1001", classify(1001), 15);
      chk("cls_927", classify(927), 1);
      chk("cls_480", classify(480), 11);
      chk("cls_479", classify(479), 15);
      chk("cls_536", classify(536), 10);
      chk("cls_954", classify(954), 0);
      chk("cls_250", classify(250), 15);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_nota", nota_a, 15);
      chk("rst_valida", val_a, 0);
      chk("rst_periodo", per_a, 0);

      // La lock.
      p0 = pulses_a;
      wave(568, 4, 0);
      chk("t1_nota", nota_a, 9);
      chk("t1_valida", val_a, 1);
      chk("t1_pulses", pulses_a - p0, 1);
      chk("t1_periodo_range", int'(per_a >= 567 && per_a <= 569), 1);

      // Switch to Do, La held through the transition.
      p0 = pulses_a;
      wave(954, 3, 0);
      chk("t2_hold_nota", nota_a, 9);
      chk("t2_hold_valida", val_a, 1);
      wave(954, 1, 0);
      chk("t2_nota", nota_a, 0);
      chk("t2_pulses", pulses_a - p0, 1);

      // Silence times out, next edge only re-arms.
      p0 = pulses_a;
      repeat (TOUT * DIV + 100) @(negedge clk);
      chk("t3_nota", nota_a, 15);
      chk("t3_valida", val_a, 0);
      chk("t3_pulses", pulses_a - p0, 1);
      p0 = pulses_a;
      wave(954, 1, 0);
      chk("t3_rearm_nota", nota_a, 15);
      chk("t3_rearm_pulses", pulses_a - p0, 0);

      // 1 kHz is out of range.
      p0 = pulses_a;
      wave(250, 6, 0);
      chk("t4_nota", nota_a, 15);
      chk("t4_pulses", pulses_a - p0, 0);

      // Alternating La/LaS: no lock with Stable=3, one update per period with Stable=1.
      p0 = pulses_a;
      q0 = pulses_b;
      for (int k = 0; k < 4; k++) begin
         wave(568, 1, 0);
         wave(536, 1, 0);
      end
      chk("t5_nota_a", nota_a, 15);
      chk("t5_pulses_a", pulses_a - p0, 0);
      chk("t5_pulses_b", pulses_b - q0, 7);
      chk("t5_nota_b", nota_b, 9);

      // Reset while locked.
      wave(568, 4, 0);
      chk("t6_lock", nota_a, 9);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_nota", nota_a, 15);
      chk("t6_valida", val_a, 0);
      chk("t6_periodo", per_a, 0);
      chk("t6_nueva", nue_a, 0);
      wave(568, 3, 0);
      chk("t6_not_yet", nota_a, 15);
      wave(568, 1, 0);
      chk("t6_relock", nota_a, 9);

      // Random notes around the band edges.
      for (int k = 0; k < 8; k++) begin
         n = int'($urandom_range(11));
         sel = int'($urandom_range(3));
         case (sel)
            0: tks = lo_b[n];
            1: tks = hi_b[n];
            2: tks = int'($urandom_range(hi_b[n], lo_b[n]));
            default: tks = int'($urandom_range(1010, 470));
         endcase
         runs = int'($urandom_range(3, 1));
         wave(tks, runs, 1);
      end
      repeat (TOUT * DIV + 100) @(negedge clk);
      chk("t7_final_nota", nota_a, 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/note_detector.md
Name: note_detector

Overview:
- Receive side of the synthesizer tone path: measures the period of an incoming square wave and identifies which of the 12 chromatic notes from Do (262 Hz) to Si (494 Hz) it is.
- Used for loopback self-test of the note outputs and for tuning external sources.
- Output is debounced: a note is reported only after STABLE consecutive matching periods.
- Sits beside the synthesizer in the 25 MHz clock domain.

Parameters:
- FrecIn, 25000000: system clock frequency in Hz.
- FrecTick, 250000: measurement tick in Hz. The note bound table is defined for this value only.
- Stable, 3: consecutive identical classifications required to update the output. Legal range 1..7.
- Timeout, 1023: ticks with no rising edge before the input is declared silent.

Ports:
- clockIn  input  1  system clock, 25 MHz.
- reset  input  1  synchronous, active-high reset.
- ondaIn  input  1  asynchronous square-wave input.
- nota  output  4  note code: 0=Do … 11=Si; 15=none.
- notaValida  output  1  high while nota holds a locked note (0..11).
- nuevaNota  output  1  one-cycle pulse whenever nota or notaValida changes.
- periodo  output  10  last measured period, in ticks.

Behaviour:
Reset
- One clockIn edge with reset=1 sets: nota=15, notaValida=0, nuevaNota=0, periodo=0, state=IDLE, cand=15, matchCnt=0, tick prescaler=0, tickCount=0.
- A reset during a locked note clears it the same way, with no nuevaNota pulse.

Input path
- ondaIn passes through a 2-FF synchronizer.
- A rising edge is detected when sync2=1 and the registered previous sync2=0.

Tick and period count
- The prescaler raises a tick every FrecIn/FrecTick = 100 clocks.
- tickCount (10 bits) increments on each tick while in MEASURE.

FSM
- IDLE: a rising edge sets tickCount=0 and moves to MEASURE. No measurement is taken on this arming edge.
- MEASURE, rising edge: periodo<=tickCount, the period is classified, then tickCount<=0. If a tick coincides with the edge, the edge wins and that tick is discarded.
- MEASURE, tickCount reaches Timeout:
  - nota<=15, notaValida<=0, cand<=15, matchCnt<=0, go to IDLE.
  - nuevaNota pulses only if notaValida was 1.

Classification (inclusive bounds, in ticks)
- Do 928-1000, DoS 876-927, Re 827-875, ReS 781-826, Mi 737-780, Fa 696-736.
- FaS 657-695, Sol 620-656, SolS 585-619, La 552-584, LaS 521-551, Si 480-520.
- Anything else gives class c=15.

Stability
- If c==cand: matchCnt<=min(matchCnt+1, Stable).
- Otherwise: cand<=c, matchCnt<=1.
- When matchCnt becomes Stable and cand≠nota:
  - nota<=cand, notaValida<=(cand≠15), nuevaNota<=1 for one cycle.
  - A stable run of class 15 clears a lock.
- Repeated matches after lock cause no further pulses.
- Alternating classes never reach Stable, so the output is unchanged.

Latency
- nota, notaValida and nuevaNota change exactly 4 clockIn cycles after the qualifying ondaIn rising edge at the pin: 2 sync, 1 classify, 1 update.
- periodo updates 3 cycles after that edge.

Decomposition:
- Package nota_pkg holds:
  - note code constants DO..SI and NOTA_NONE=4'hF;
  - the 12 lower/upper bound constants;
  - TICK_DIV.
- Sub-module period_classifier is the combinational 10-bit period to 4-bit class lookup over the package bounds, instantiated once.
- Synchronizer, prescaler, FSM and stability logic stay in note_detector.

Test Plan:
1. 440 Hz wave (56818 clocks/period) after reset → after the arming edge plus 3 periods: nota=9, notaValida=1, one nuevaNota pulse, periodo 567-569.
2. Locked at 440 Hz, switch to 262 Hz → 3 periods later nota=0, one pulse. nota stays 9 with notaValida=1 during the transition.
3. Locked, then ondaIn held low → 1023 ticks (102300 clocks) after the last edge: nota=15, notaValida=0, one pulse, FSM in IDLE. The next edge only re-arms.
4. 1 kHz wave (period 250 ticks) → never valid, nota=15, no pulse.
5. Per-period alternation 440/466 Hz → no lock, nota stays 15. Repeat with Stable=1 → nota updates on every period.
6. Locked on La, assert reset for 1 cycle → next cycle nota=15, notaValida=0, periodo=0, no pulse. Relock needs arming plus 3 periods.
